morse_keyer: RTL and testbench

MORSE_KEYER -- requirements
Module: morse_keyer

---
 rtl/morse_pkg.sv | 35 +++
 rtl/morse_encoder.sv | 43 ++++
 rtl/morse_keyer.sv | 121 ++++++++++++
 tb/tb_morse_keyer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer.
package morse_pkg;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned LEN_W = 3;

    // Durations in Morse units
    localparam int unsigned DOT_UNITS        = 1;
    localparam int unsigned DASH_UNITS       = 3;
    localparam int unsigned CHAR_EXTRA_UNITS = 2;
    localparam int unsigned WORD_EXTRA_UNITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_CHAR_GAP,
        ST_WORD_GAP
    } state_e;

    // Encoded character: pattern bit 1 = dash, sent from bit[length-1] down to bit[0]
    typedef struct packed {
        logic [PAT_W-1:0] pattern;
        logic [LEN_W-1:0] length;
    } morse_code_t;

    function automatic morse_code_t make_code(input logic [PAT_W-1:0] pattern,
                                              input logic [LEN_W-1:0] length);
        morse_code_t c;
        c.pattern = pattern;
        c.length  = length;
        return c;
    endfunction

endpackage

// File: rtl/morse_encoder.sv
// Combinational ASCII to Morse lookup; unsupported codes give length 0.
module morse_encoder
    import morse_pkg::*;
(
    input  logic [7:0]  char_in,
    output morse_code_t code
);

    // Table lookup for uppercase letters
    always_comb begin
        code = make_code(8'b0, 3'd0);
        case (char_in)
            8'h41: code = make_code(8'b01,   3'd2); // A .-
            8'h42: code = make_code(8'b1000, 3'd4); // B -...
            8'h43: code = make_code(8'b1010, 3'd4); // C -.-.
            8'h44: code = make_code(8'b100,  3'd3); // D -..
            8'h45: code = make_code(8'b0,    3'd1); // E .
            8'h46: code = make_code(8'b0010, 3'd4); // F ..-.
            8'h47: code = make_code(8'b110,  3'd3); // G --.
            8'h48: code = make_code(8'b0000, 3'd4); // H ....
            8'h49: code = make_code(8'b00,   3'd2); // I ..
            8'h4A: code = make_code(8'b0111, 3'd4); // J .---
            8'h4B: code = make_code(8'b101,  3'd3); // K -.-
            8'h4C: code = make_code(8'b0100, 3'd4); // L .-..
            8'h4D: code = make_code(8'b11,   3'd2); // M --
            8'h4E: code = make_code(8'b10,   3'd2); // N -.
            8'h4F: code = make_code(8'b111,  3'd3); // O ---
            8'h50: code = make_code(8'b0110, 3'd4); // P .--.
            8'h51: code = make_code(8'b1101, 3'd4); // Q --.-
            8'h52: code = make_code(8'b010,  3'd3); // R .-.
            8'h53: code = make_code(8'b000,  3'd3); // S ...
            8'h54: code = make_code(8'b1,    3'd1); // T -
            8'h55: code = make_code(8'b001,  3'd3); // U ..-
            8'h56: code = make_code(8'b0001, 3'd4); // V ...-
            8'h57: code = make_code(8'b011,  3'd3); // W .--
            8'h58: code = make_code(8'b1001, 3'd4); // X -..-
            8'h59: code = make_code(8'b1011, 3'd4); // Y -.--
            8'h5A: code = make_code(8'b1100, 3'd4); // Z --..
            default: code = make_code(8'b0, 3'd0);
        endcase
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one ASCII character at a time and keys it out with
// standard dot/dash/gap timing measured in UNIT_CYCLES clock cycles per unit.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [7:0] char_in,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(4 * UNIT_CYCLES) + 1;

    localparam logic [CNT_W-1:0] DOT_LOAD   = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD  = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPACE_LOAD = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHAR_LOAD  = CNT_W'(CHAR_EXTRA_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_LOAD  = CNT_W'(WORD_EXTRA_UNITS * UNIT_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] rem;

    morse_code_t code_c;
    logic        accept_c;
    logic        first_dash_c;
    logic        next_dash_c;

    morse_encoder u_encoder (
        .char_in (char_in),
        .code    (code_c)
    );

    // Acceptance and the element type of the first/next mark
    always_comb begin
        accept_c     = char_valid & char_ready;
        first_dash_c = code_c.pattern[code_c.length - LEN_W'(1)];
        next_dash_c  = pat[rem - LEN_W'(1)];
    end

    // Keyer state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pat        <= '0;
            rem        <= '0;
            key_out    <= 1'b0;
            busy       <= 1'b0;
            char_ready <= 1'b0;
        end else if (accept_c) begin
            pat        <= code_c.pattern;
            rem        <= code_c.length;
            busy       <= 1'b1;
            char_ready <= 1'b0;
            if (code_c.length != LEN_W'(0)) begin
                state   <= ST_MARK;
                key_out <= 1'b1;
                cnt     <= first_dash_c ? DASH_LOAD : DOT_LOAD;
            end else begin
                state   <= ST_WORD_GAP;
                key_out <= 1'b0;
                cnt     <= WORD_LOAD;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    char_ready <= 1'b1;
                    busy       <= 1'b0;
                    key_out    <= 1'b0;
                end
                ST_MARK: begin
                    if (cnt != CNT_W'(0)) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state   <= ST_SPACE;
                        key_out <= 1'b0;
                        cnt     <= SPACE_LOAD;
                        rem     <= rem - LEN_W'(1);
                    end
                end
                ST_SPACE: begin
                    if (cnt != CNT_W'(0)) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (rem != LEN_W'(0)) begin
                        state   <= ST_MARK;
                        key_out <= 1'b1;
                        cnt     <= next_dash_c ? DASH_LOAD : DOT_LOAD;
                    end else begin
                        state <= ST_CHAR_GAP;
                        cnt   <= CHAR_LOAD;
                    end
                end
                ST_CHAR_GAP, ST_WORD_GAP: begin
                    // Ready rises together with the counter reaching its final cycle
                    if (cnt != CNT_W'(0)) begin
                        cnt        <= cnt - CNT_W'(1);
                        char_ready <= (cnt == CNT_W'(1));
                    end else begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    key_out    <= 1'b0;
                    busy       <= 1'b0;
                    char_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Testbench for morse_keyer: behavioural timeline model plus directed timing checks.
module tb_morse_keyer;

    localparam int unsigned U    = 2;
    localparam int          MAXC = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_ready;
    logic       key_out;
    logic       busy;

    morse_keyer #(.UNIT_CYCLES(U)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_in    (char_in),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n      = 0;
    int errors = 0;
    int checks = 0;

    // Model: queue of expected key levels for the cycles of the character in flight
    bit q[$];
    bit rst_prev  = 1'b1;
    bit exp_key   = 1'b0;
    bit exp_busy  = 1'b0;
    bit exp_ready = 1'b0;

    logic key_log   [MAXC];
    logic ready_log [MAXC];
    logic busy_log  [MAXC];

    string morse_tab [26] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--.."
    };

    function automatic string morse_of(input logic [7:0] c);
        if (c >= 8'd65 && c <= 8'd90) return morse_tab[int'(c) - 65];
        return "";
    endfunction

    // Expand a character into its full key timeline, including the trailing gap
    task automatic push_char(input logic [7:0] c);
        string m;
        m = morse_of(c);
        if (m.len() == 0) begin
            repeat (4 * U) q.push_back(1'b0);
        end else begin
            for (int i = 0; i < m.len(); i++) begin
                int d;
                d = (m[i] == 8'h2D) ? 3 * U : U;
                repeat (d) q.push_back(1'b1);
                repeat (U) q.push_back(1'b0);
            end
            repeat (2 * U) q.push_back(1'b0);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, n, act, exp);
        end
    endtask

    // Drive one cycle of inputs, step the model, then compare after the edge
    task automatic cycle(input logic v, input logic [7:0] c, input logic r, output bit acc);
        char_valid = v;
        char_in    = c;
        rst        = r;
        acc        = 1'b0;
        if (r) begin
            q.delete();
        end else if (v && exp_ready) begin
            push_char(c);
            acc = 1'b1;
        end
        rst_prev = r;
        @(posedge clk);
        #1;
        n++;
        if (rst_prev) begin
            exp_key = 1'b0; exp_busy = 1'b0; exp_ready = 1'b0;
        end else if (q.size() > 0) begin
            exp_key   = q.pop_front();
            exp_busy  = 1'b1;
            exp_ready = (q.size() == 0);
        end else begin
            exp_key = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
        end
        chk("key_out", int'(key_out), int'(exp_key));
        chk("busy", int'(busy), int'(exp_busy));
        chk("char_ready", int'(char_ready), int'(exp_ready));
        if (n < MAXC) begin
            key_log[n]   = key_out;
            ready_log[n] = char_ready;
            busy_log[n]  = busy;
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] c, input logic r);
        bit a;
        cycle(v, c, r, a);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(1'b0, 8'($urandom_range(0, 255)), 1'b0);
    endtask

    // Hold char_valid until accepted; returns the accept cycle
    task automatic send(input logic [7:0] c, output int t);
        bit a;
        int t0;
        t = -1;
        for (int k = 0; k < 200; k++) begin
            t0 = n;
            cycle(1'b1, c, 1'b0, a);
            if (a) begin
                t = t0;
                break;
            end
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout char=%0h got=no_accept want=accept", c);
            t = n;
        end
    endtask

    function automatic int key_run(input int s, input logic val);
        int k = 0;
        while (s + k < MAXC && s + k <= n && key_log[s + k] === val) k++;
        return k;
    endfunction

    function automatic int busy_run(input int s);
        int k = 0;
        while (s + k < MAXC && s + k <= n && busy_log[s + k] === 1'b1) k++;
        return k;
    endfunction

    initial begin
        int t, t2, t3;
        int r;
        logic [7:0] ch;

        // Reset state
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        chk("rst_key", int'(key_log[n]), 0);
        chk("rst_ready", int'(ready_log[n]), 0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        chk("post_rst_ready", int'(ready_log[n]), 1);

        // "E" from idle
        send(8'h45, t);
        idle(20);
        chk("E_key_t1", int'(key_log[t + 1]), 1);
        chk("E_key_t2", int'(key_log[t + 2]), 1);
        chk("E_key_t3", int'(key_log[t + 3]), 0);
        chk("E_ready_t7", int'(ready_log[t + 7]), 0);
        chk("E_ready_t8", int'(ready_log[t + 8]), 1);
        chk("E_idle_t9", int'(busy_log[t + 9]), 0);

        // "A": dot then dash
        send(8'h41, t);
        idle(20);
        chk("A_dot_len", key_run(t + 1, 1'b1), 2);
        chk("A_space_len", key_run(t + 3, 1'b0), 2);
        chk("A_dash_len", key_run(t + 5, 1'b1), 6);
        chk("A_ready_t15", int'(ready_log[t + 15]), 0);
        chk("A_ready_t16", int'(ready_log[t + 16]), 1);

        // "E","T" back to back
        send(8'h45, t);
        send(8'h54, t2);
        idle(20);
        chk("ET_accept2", t2 - t, 8);
        chk("ET_gap", key_run(t + 3, 1'b0), 6);
        chk("ET_T_mark", key_run(t + 9, 1'b1), 6);

        // "E"," ","E": word spacing
        send(8'h45, t);
        send(8'h20, t2);
        send(8'h45, t3);
        idle(20);
        chk("ESE_gap", key_run(t + 3, 1'b0), 14);
        chk("ESE_accept3", t3 - t, 16);

        // Unsupported "5"
        send(8'h35, t);
        idle(20);
        chk("5_busy_len", busy_run(t + 1), 8);
        chk("5_no_mark", key_run(t + 1, 1'b0) >= 8 ? 1 : 0, 1);
        chk("5_ready_t8", int'(ready_log[t + 8]), 1);

        // Reset during the dash of "T", then a clean "E"
        send(8'h54, t);
        idle(2);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
        chk("rstT_mark_before", int'(key_log[t + 3]), 1);
        chk("rstT_key_after", int'(key_log[t + 4]), 0);
        chk("rstT_busy_after", int'(busy_log[t + 4]), 0);
        chk("rstT_ready_release", int'(ready_log[t + 5]), 1);
        send(8'h45, t2);
        idle(12);
        chk("rstT_E_accept", t2 - t, 5);
        chk("rstT_E_mark", key_run(t2 + 1, 1'b1), 2);
        chk("rstT_E_ready", int'(ready_log[t2 + 8]), 1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       ch = 8'(65 + $urandom_range(0, 25));
            else if (r < 8)  ch = 8'h20;
            else             ch = 8'($urandom_range(0, 255));
            tick(($urandom_range(0, 3) != 0), ch, ($urandom_range(0, 299) == 0));
        end
        idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
